// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment driver: shadow-loaded digit codes scanned onto a shared segment bus.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_SUPPRESS_EN.
module seg7_scan_driver #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 1024,
  parameter int unsigned CNT_W    = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   nibbles,
  input  logic [DIGITS-1:0]     blank,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     dig_sel,
  output logic                  frame_done
);

  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CNT_W-1:0]         r_cnt;
  logic [IDX_W-1:0]         r_idx;
  logic [DIGITS-1:0][3:0]   r_code;
  logic [DIGITS-1:0]        r_blank;

  logic                     w_slot_end;
  logic                     w_frame_end;
  logic [DIGITS-1:0]        w_dark;
  logic [6:0]               w_seg;

  function automatic logic [6:0] f_decode(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110010;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      4'd15:   s = 7'b0000001;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

`ifdef LEADING_ZERO_SUPPRESS_EN
  logic [DIGITS-1:0] w_supp;

  // Walk from the most significant digit; a zero stays dark while everything above is zero or dark.
  always_comb begin
    logic v_all_zero_above;
    v_all_zero_above = 1'b1;
    w_supp           = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      w_supp[k]        = (k != 0) && v_all_zero_above && (r_code[k] == 4'd0);
      v_all_zero_above = v_all_zero_above && ((r_code[k] == 4'd0) || r_blank[k]);
    end
  end

  assign w_dark = r_blank | w_supp;
`else
  assign w_dark = r_blank;
`endif

  always_comb begin
    w_slot_end  = (r_cnt == CNT_W'(SCAN_DIV - 1));
    w_frame_end = w_slot_end && (r_idx == IDX_W'(DIGITS - 1));
    w_seg       = w_dark[r_idx] ? 7'b0000000 : f_decode(r_code[r_idx]);
  end

  // Shadow registers, scan counters and registered display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      r_code     <= '0;
      r_blank    <= '1;
      seg        <= '0;
      dig_sel    <= '0;
      frame_done <= 1'b0;
    end else begin
      if (load) begin
        r_code  <= nibbles;
        r_blank <= blank;
      end

      if (w_slot_end) begin
        r_cnt <= '0;
        if (r_idx == IDX_W'(DIGITS - 1)) r_idx <= '0;
        else                             r_idx <= r_idx + IDX_W'(1);
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      // First cycle of every slot is a dark guard cycle against ghosting.
      if (r_cnt == '0) begin
        seg     <= '0;
        dig_sel <= '0;
      end else begin
        seg     <= w_seg;
        dig_sel <= DIGITS'(1) << r_idx;
      end

      frame_done <= w_frame_end;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with DIGITS=4, SCAN_DIV=4; honours LEADING_ZERO_SUPPRESS_EN.
module tb_seg7_scan_driver;

  localparam int unsigned DIGITS   = 4;
  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned CNT_W    = 2;

  localparam logic [6:0] S0 = 7'b1111110;
  localparam logic [6:0] S1 = 7'b0110000;
  localparam logic [6:0] S2 = 7'b1101101;
  localparam logic [6:0] S3 = 7'b1111001;
  localparam logic [6:0] S4 = 7'b0110011;
  localparam logic [6:0] S5 = 7'b1011011;
  localparam logic [6:0] S8 = 7'b1111111;
  localparam logic [6:0] S9 = 7'b1111011;
  localparam logic [6:0] SM = 7'b0000001;
  localparam logic [6:0] SX = 7'b0000000;

`ifdef LEADING_ZERO_SUPPRESS_EN
  localparam bit LZS = 1'b1;
`else
  localparam bit LZS = 1'b0;
`endif

  logic                 clk;
  logic                 rst;
  logic                 load;
  logic [4*DIGITS-1:0]  nibbles;
  logic [DIGITS-1:0]    blank;
  logic [6:0]           seg;
  logic [DIGITS-1:0]    dig_sel;
  logic                 frame_done;

  int checks;
  int failures;

  seg7_scan_driver #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .nibbles    (nibbles),
    .blank      (blank),
    .seg        (seg),
    .dig_sel    (dig_sel),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts with the scan at cnt=0/idx=0; runs 16 cycles and ends aligned the same way.
  task automatic run_frame(input string name, input bit do_load,
                           input logic [15:0] nib, input logic [3:0] blk,
                           input logic [6:0] e0, input logic [6:0] e1,
                           input logic [6:0] e2, input logic [6:0] e3);
    logic [6:0] exp_seg [4];
    logic [6:0] es;
    logic [3:0] ed;
    logic       ef;
    int         cnt;
    int         idx;
    exp_seg[0] = e0; exp_seg[1] = e1; exp_seg[2] = e2; exp_seg[3] = e3;
    for (int j = 1; j <= 16; j++) begin
      if (j == 1 && do_load) begin
        load = 1'b1; nibbles = nib; blank = blk;
      end
      step();
      load = 1'b0;
      cnt = (j - 1) % 4;
      idx = (j - 1) / 4;
      es  = (cnt == 0) ? SX : exp_seg[idx];
      ed  = (cnt == 0) ? 4'b0000 : 4'(1 << idx);
      ef  = (j == 16);
      checks++;
      if (seg !== es || dig_sel !== ed || frame_done !== ef) begin
        failures++;
        $display("FAIL %s cycle %0d: seg=%b dig_sel=%b frame_done=%b expected seg=%b dig_sel=%b frame_done=%b",
                 name, j, seg, dig_sel, frame_done, es, ed, ef);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b0; nibbles = 16'h0000; blank = 4'b0000;
    step();
    step();
    checks++;
    if (seg !== 7'b0 || dig_sel !== 4'b0 || frame_done !== 1'b0) begin
      failures++;
      $display("FAIL reset: seg=%b dig_sel=%b frame_done=%b expected all zero", seg, dig_sel, frame_done);
    end
    rst = 1'b0;
  endtask

  task automatic test_idle();
    run_frame("idle_a", 1'b0, 16'h0, 4'h0, SX, SX, SX, SX);
    run_frame("idle_b", 1'b0, 16'h0, 4'h0, SX, SX, SX, SX);
  endtask

  task automatic test_digits();
    run_frame("digits_1234", 1'b1, 16'h1234, 4'b0000, S4, S3, S2, S1);
    run_frame("digits_hold", 1'b0, 16'h0, 4'h0, S4, S3, S2, S1);
    run_frame("digits_f00a", 1'b1, 16'hF00A, 4'b0100, SX, S0, SX, SM);
  endtask

  // Load coinciding with the idx 1->2 slot change, then a mid-slot load in digit 3.
  task automatic test_back_to_back();
    logic [6:0] d3z;
    logic [6:0] es;
    logic [3:0] ed;
    int         cnt;
    int         idx;
    d3z = LZS ? SX : S0;
    run_frame("pre_0500", 1'b1, 16'h0500, 4'b0000, S0, S0, S5, d3z);
    for (int j = 1; j <= 16; j++) begin
      if (j == 8)  begin load = 1'b1; nibbles = 16'h0900; blank = 4'b0000; end
      if (j == 14) begin load = 1'b1; nibbles = 16'h8900; blank = 4'b0000; end
      step();
      load = 1'b0;
      cnt = (j - 1) % 4;
      idx = (j - 1) / 4;
      ed  = (cnt == 0) ? 4'b0000 : 4'(1 << idx);
      case (idx)
        0, 1:    es = S0;
        2:       es = (j <= 8) ? S5 : S9;
        default: es = (j <= 14) ? d3z : S8;
      endcase
      if (cnt == 0) es = SX;
      checks++;
      if (seg !== es || dig_sel !== ed || frame_done !== (j == 16)) begin
        failures++;
        $display("FAIL back_to_back cycle %0d: seg=%b dig_sel=%b frame_done=%b expected seg=%b dig_sel=%b frame_done=%b",
                 j, seg, dig_sel, frame_done, es, ed, (j == 16));
      end
    end
  endtask

  task automatic test_leading_zero();
    if (LZS) begin
      run_frame("lz_0040", 1'b1, 16'h0040, 4'b0000, S0, S4, SX, SX);
      run_frame("lz_0000", 1'b1, 16'h0000, 4'b0000, S0, SX, SX, SX);
    end else begin
      run_frame("lz_0040", 1'b1, 16'h0040, 4'b0000, S0, S4, S0, S0);
      run_frame("lz_0000", 1'b1, 16'h0000, 4'b0000, S0, S0, S0, S0);
    end
  endtask

  // Reset at cnt=2 of idx 2 while a load is requested; reset must win.
  task automatic test_reset_midscan();
    for (int j = 1; j <= 10; j++) step();
    rst = 1'b1; load = 1'b1; nibbles = 16'h8888; blank = 4'b0000;
    step();
    rst = 1'b0; load = 1'b0;
    checks++;
    if (seg !== 7'b0 || dig_sel !== 4'b0 || frame_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: seg=%b dig_sel=%b frame_done=%b expected all zero", seg, dig_sel, frame_done);
    end
    step();
    checks++;
    if (seg !== 7'b0 || dig_sel !== 4'b0) begin
      failures++;
      $display("FAIL reset_guard: seg=%b dig_sel=%b expected 0000000 0000", seg, dig_sel);
    end
    step();
    checks++;
    if (seg !== 7'b0 || dig_sel !== 4'b0001) begin
      failures++;
      $display("FAIL reset_relit: seg=%b dig_sel=%b expected 0000000 0001", seg, dig_sel);
    end
    for (int j = 3; j <= 16; j++) step();
    run_frame("post_reset_dark", 1'b0, 16'h0, 4'h0, SX, SX, SX, SX);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_idle();
    test_digits();
    test_back_to_back();
    test_leading_zero();
    test_reset_midscan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
